// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 host port.
//   rx_state_t  - receive frame FSM states
//   tx_state_t  - host-to-device transmit FSM states
//   ps2_event_t - decoded key event {ext, make, code}
//   PS2_EXT / PS2_BRK - extended and break prefix bytes
//   odd_parity() - parity bit that makes data+parity odd
package ps2_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_INHIBIT,
        TX_REQ,
        TX_BITS,
        TX_ACK
    } tx_state_t;

    typedef struct packed {
        logic       ext;
        logic       make;
        logic [7:0] code;
    } ps2_event_t;

    localparam int         EVENT_W = $bits(ps2_event_t);
    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// ps2_fifo: small synchronous FIFO for decoded key events.
// Parameters: DEPTH (power of two, 2..16).
// Ports:
//   clock, reset      - clock, asynchronous active-low reset
//   push, push_data   - write request and event word (dropped when full
//                       unless a pop happens in the same cycle)
//   pop               - remove head (ignored when empty)
//   head              - current head word, read straight from storage flops
//   full, empty       - occupancy flags
module ps2_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic [EVENT_W-1:0] push_data,
    input  logic               pop,
    output logic [EVENT_W-1:0] head,
    output logic               full,
    output logic               empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [EVENT_W-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W:0]     count_reg;
    logic               do_push;
    logic               do_pop;

    assign full    = (count_reg == (PTR_W + 1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_pop  = pop && !empty;
    // When full, a same-cycle pop frees the slot being written (wr == rd),
    // and the popped word has already been presented this cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem_reg[rd_ptr_reg];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_reg[wr_ptr_reg] <= push_data;
                wr_ptr_reg          <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/ps2_host.sv
// ps2_host: PS/2 keyboard host port.
// Receives device frames through a glitch filter, folds E0/F0 prefixes into
// {ext, make, code} events and queues them in a FIFO with a valid/ready head.
// Optional host-to-device transmitter is built when macro PS2_TX_EN is defined;
// otherwise the tx outputs are tied inactive and txStrb/txData are ignored.
// Parameters: FILTER, FIFO_DEPTH, TIMEOUT_W, INHIBIT.
// Ports:
//   clock, reset        - system clock, asynchronous active-low reset
//   ce                  - sample enable for everything except the FIFO read side
//   ps2CkI, ps2DI       - raw PS/2 clock/data pins
//   ps2CkO, ps2DO       - 1 = pull clock/data pin low (open drain)
//   valid, ready        - FIFO head handshake
//   make, ext, code     - FIFO head event
//   overflow            - pulse: event dropped on full FIFO
//   frameErr            - pulse: start/parity/stop error or watchdog timeout
//   txStrb, txData      - transmit request and byte
//   txBusy, txAck       - transmit in progress, device acknowledge pulse
module ps2_host
    import ps2_pkg::*;
#(
    parameter int FILTER     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT_W  = 12,
    parameter int INHIBIT    = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       ps2CkI,
    input  logic       ps2DI,
    output logic       ps2CkO,
    output logic       ps2DO,
    output logic       valid,
    input  logic       ready,
    output logic       make,
    output logic       ext,
    output logic [7:0] code,
    output logic       overflow,
    output logic       frameErr,
    input  logic       txStrb,
    input  logic [7:0] txData,
    output logic       txBusy,
    output logic       txAck
);

    localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

    // ---------------- input synchronisers and clock filter ----------------
    logic [1:0]        ck_sync_reg;
    logic [1:0]        d_sync_reg;
    logic [FILTER-1:0] filt_reg;
    logic [FILTER-1:0] filt_next;
    logic              ck_filt_reg;
    logic              fall_reg;
    logic              d_s;

    assign d_s       = d_sync_reg[1];
    assign filt_next = {filt_reg[FILTER-2:0], ck_sync_reg[1]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ck_sync_reg <= 2'b11;
            d_sync_reg  <= 2'b11;
            filt_reg    <= '1;
            ck_filt_reg <= 1'b1;
            fall_reg    <= 1'b0;
        end else if (ce) begin
            ck_sync_reg <= {ck_sync_reg[0], ps2CkI};
            d_sync_reg  <= {d_sync_reg[0], ps2DI};
            filt_reg    <= filt_next;
            fall_reg    <= 1'b0;
            if (&filt_next) begin
                ck_filt_reg <= 1'b1;
            end else if (~|filt_next && ck_filt_reg) begin
                // fall_reg holds for exactly one ce period, so consumers
                // act on it at the next ce
                ck_filt_reg <= 1'b0;
                fall_reg    <= 1'b1;
            end
        end
    end

    // ---------------- shared frame watchdog ----------------
    rx_state_t            rx_state_reg;
    logic [TIMEOUT_W-1:0] wd_reg;
    logic                 wd_active;
    logic                 timeout;
    logic                 tx_guard;
    logic                 tx_busy;
    logic                 tx_err;

    assign wd_active = (rx_state_reg != RX_IDLE) || tx_guard;
    // A fall on the same tick means the link is alive; it wins.
    assign timeout   = ce && wd_active && !fall_reg && (wd_reg == WD_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_reg <= '0;
        end else if (ce) begin
            if (!wd_active || fall_reg || timeout) begin
                wd_reg <= '0;
            end else begin
                wd_reg <= wd_reg + 1'b1;
            end
        end
    end

    // ---------------- receive FSM and prefix decoder ----------------
    logic [2:0] bit_cnt_reg;
    logic [7:0] shift_reg;
    logic       par_reg;
    logic       ext_flag_reg;
    logic       make_flag_reg;
    logic       push_req_reg;
    ps2_event_t push_data_reg;
    logic       rx_err_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_state_reg  <= RX_IDLE;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            par_reg       <= 1'b0;
            ext_flag_reg  <= 1'b0;
            make_flag_reg <= 1'b1;
            push_req_reg  <= 1'b0;
            push_data_reg <= '0;
            rx_err_reg    <= 1'b0;
        end else begin
            rx_err_reg <= 1'b0;
            if (ce) begin
                // a pending push is taken by the FIFO on this ce
                if (push_req_reg) begin
                    push_req_reg <= 1'b0;
                end
                if (timeout && (rx_state_reg != RX_IDLE)) begin
                    rx_state_reg  <= RX_IDLE;
                    ext_flag_reg  <= 1'b0;
                    make_flag_reg <= 1'b1;
                    rx_err_reg    <= 1'b1;
                end else if (fall_reg && !tx_busy) begin
                    case (rx_state_reg)
                        RX_IDLE: begin
                            if (!d_s) begin
                                rx_state_reg <= RX_DATA;
                                bit_cnt_reg  <= '0;
                            end
                        end
                        RX_DATA: begin
                            shift_reg   <= {d_s, shift_reg[7:1]};
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            if (bit_cnt_reg == 3'd7) begin
                                rx_state_reg <= RX_PARITY;
                            end
                        end
                        RX_PARITY: begin
                            par_reg      <= d_s;
                            rx_state_reg <= RX_STOP;
                        end
                        RX_STOP: begin
                            rx_state_reg <= RX_IDLE;
                            if (d_s && (^{shift_reg, par_reg})) begin
                                if (shift_reg == PS2_EXT) begin
                                    ext_flag_reg <= 1'b1;
                                end else if (shift_reg == PS2_BRK) begin
                                    make_flag_reg <= 1'b0;
                                end else begin
                                    push_req_reg       <= 1'b1;
                                    push_data_reg.ext  <= ext_flag_reg;
                                    push_data_reg.make <= make_flag_reg;
                                    push_data_reg.code <= shift_reg;
                                    ext_flag_reg       <= 1'b0;
                                    make_flag_reg      <= 1'b1;
                                end
                            end else begin
                                ext_flag_reg  <= 1'b0;
                                make_flag_reg <= 1'b1;
                                rx_err_reg    <= 1'b1;
                            end
                        end
                        default: rx_state_reg <= RX_IDLE;
                    endcase
                end
            end
        end
    end

    // ---------------- event FIFO ----------------
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [EVENT_W-1:0] fifo_head;
    ps2_event_t         head_evt;
    logic               overflow_reg;

    assign fifo_push = push_req_reg && ce;
    assign fifo_pop  = !fifo_empty && ready;
    assign head_evt  = fifo_head;

    ps2_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (fifo_push),
        .push_data(push_data_reg),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow_reg <= 1'b0;
        end else begin
            overflow_reg <= fifo_push && fifo_full && !fifo_pop;
        end
    end

    assign valid    = !fifo_empty;
    assign ext      = head_evt.ext;
    assign make     = head_evt.make;
    assign code     = head_evt.code;
    assign overflow = overflow_reg;
    assign frameErr = rx_err_reg || tx_err;

    // ---------------- host-to-device transmitter ----------------
`ifdef PS2_TX_EN
    localparam int             INH_W    = $clog2(INHIBIT + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT - 1);

    tx_state_t        tx_state_reg;
    logic [8:0]       tx_shift_reg;
    logic [3:0]       tx_idx_reg;
    logic [INH_W-1:0] inh_cnt_reg;
    logic             ck_o_reg;
    logic             d_o_reg;
    logic             tx_busy_reg;
    logic             tx_ack_reg;
    logic             tx_err_reg;

    assign tx_guard = (tx_state_reg == TX_BITS) || (tx_state_reg == TX_ACK);
    assign tx_busy  = tx_busy_reg;
    assign tx_err   = tx_err_reg;
    assign ps2CkO   = ck_o_reg;
    assign ps2DO    = d_o_reg;
    assign txBusy   = tx_busy_reg;
    assign txAck    = tx_ack_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_state_reg <= TX_IDLE;
            tx_shift_reg <= '0;
            tx_idx_reg   <= '0;
            inh_cnt_reg  <= '0;
            ck_o_reg     <= 1'b0;
            d_o_reg      <= 1'b0;
            tx_busy_reg  <= 1'b0;
            tx_ack_reg   <= 1'b0;
            tx_err_reg   <= 1'b0;
        end else begin
            tx_ack_reg <= 1'b0;
            tx_err_reg <= 1'b0;
            if (ce) begin
                if (timeout && tx_guard) begin
                    tx_state_reg <= TX_IDLE;
                    ck_o_reg     <= 1'b0;
                    d_o_reg      <= 1'b0;
                    tx_busy_reg  <= 1'b0;
                    tx_err_reg   <= 1'b1;
                end else begin
                    case (tx_state_reg)
                        TX_IDLE: begin
                            if (txStrb && (rx_state_reg == RX_IDLE)) begin
                                tx_shift_reg <= {odd_parity(txData), txData};
                                tx_busy_reg  <= 1'b1;
                                ck_o_reg     <= 1'b1;
                                d_o_reg      <= 1'b0;
                                inh_cnt_reg  <= '0;
                                tx_state_reg <= TX_INHIBIT;
                            end
                        end
                        TX_INHIBIT: begin
                            if (inh_cnt_reg == INH_LAST) begin
                                // release clock, pull data low as start bit
                                ck_o_reg     <= 1'b0;
                                d_o_reg      <= 1'b1;
                                tx_state_reg <= TX_REQ;
                            end else begin
                                inh_cnt_reg <= inh_cnt_reg + 1'b1;
                            end
                        end
                        TX_REQ: begin
                            if (fall_reg) begin
                                d_o_reg      <= ~tx_shift_reg[0];
                                tx_shift_reg <= {1'b0, tx_shift_reg[8:1]};
                                tx_idx_reg   <= 4'd1;
                                tx_state_reg <= TX_BITS;
                            end
                        end
                        TX_BITS: begin
                            if (fall_reg) begin
                                if (tx_idx_reg == 4'd9) begin
                                    // data and parity sent: release for stop
                                    d_o_reg      <= 1'b0;
                                    tx_state_reg <= TX_ACK;
                                end else begin
                                    d_o_reg      <= ~tx_shift_reg[0];
                                    tx_shift_reg <= {1'b0, tx_shift_reg[8:1]};
                                    tx_idx_reg   <= tx_idx_reg + 1'b1;
                                end
                            end
                        end
                        TX_ACK: begin
                            if (fall_reg) begin
                                if (!d_s) begin
                                    tx_ack_reg <= 1'b1;
                                end else begin
                                    tx_err_reg <= 1'b1;
                                end
                                tx_busy_reg  <= 1'b0;
                                tx_state_reg <= TX_IDLE;
                            end
                        end
                        default: tx_state_reg <= TX_IDLE;
                    endcase
                end
            end
        end
    end
`else
    logic unused_tx;

    assign unused_tx = ^{txStrb, txData};
    assign tx_guard  = 1'b0;
    assign tx_busy   = 1'b0;
    assign tx_err    = 1'b0;
    assign ps2CkO    = 1'b0;
    assign ps2DO     = 1'b0;
    assign txBusy    = 1'b0;
    assign txAck     = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_host.sv
// tb_ps2_host: self-checking bench for ps2_host.
// A device model drives PS/2 frames onto open-drain pins; expected events
// are queued when each frame is sent and a monitor pops and compares them
// whenever the DUT head is accepted. Pulse outputs are counted by the monitor.
module tb_ps2_host;

    localparam int FILTER = 4;
    localparam int DEPTH  = 4;
    localparam int TW     = 8;
    localparam int INH    = 20;
    localparam int HALF   = 30;   // clocks per half PS/2 clock period

    logic       clock = 1'b0;
    logic       reset;
    logic       ce;
    logic       ps2CkI;
    logic       ps2DI;
    logic       ps2CkO;
    logic       ps2DO;
    logic       valid;
    logic       ready;
    logic       make;
    logic       ext;
    logic [7:0] code;
    logic       overflow;
    logic       frameErr;
    logic       txStrb;
    logic [7:0] txData;
    logic       txBusy;
    logic       txAck;

    logic dev_ck = 1'b1;
    logic dev_d  = 1'b1;

    int errors = 0;
    int checks = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int ack_cnt = 0;
    logic [9:0] exp_q[$];

    // open-drain wires: either side can pull low
    assign ps2CkI = dev_ck & ~ps2CkO;
    assign ps2DI  = dev_d & ~ps2DO;

    always #5 clock = ~clock;

    // ce on every other clock so ce gating is exercised
    always @(posedge clock or negedge reset) begin
        if (!reset) ce <= 1'b0;
        else        ce <= ~ce;
    end

    ps2_host #(
        .FILTER    (FILTER),
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT_W (TW),
        .INHIBIT   (INH)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .ce      (ce),
        .ps2CkI  (ps2CkI),
        .ps2DI   (ps2DI),
        .ps2CkO  (ps2CkO),
        .ps2DO   (ps2DO),
        .valid   (valid),
        .ready   (ready),
        .make    (make),
        .ext     (ext),
        .code    (code),
        .overflow(overflow),
        .frameErr(frameErr),
        .txStrb  (txStrb),
        .txData  (txData),
        .txBusy  (txBusy),
        .txAck   (txAck)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clock) begin
        if (reset) begin
            if (frameErr) fe_cnt++;
            if (overflow) ov_cnt++;
            if (txAck)    ack_cnt++;
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got %h expected none", {ext, make, code});
                end else begin
                    logic [9:0] e;
                    e = exp_q.pop_front();
                    $display("event ext=%b make=%b code=%h (expected %h)", ext, make, code, e);
                    check("event", {22'b0, ext, make, code}, {22'b0, e});
                end
            end
        end
    end

    task automatic dev_bit(input logic b);
        dev_d = b;
        repeat (HALF) @(negedge clock);
        dev_ck = 1'b0;
        repeat (HALF) @(negedge clock);
        dev_ck = 1'b1;
    endtask

    // nbits < 8 stops the device clock mid-frame
    task automatic send_frame(input logic [7:0] b, input logic flip_par, input int nbits);
        $display("frame tx byte=%h flip_parity=%b bits=%0d", b, flip_par, nbits);
        @(negedge clock);
        dev_bit(1'b0);
        for (int i = 0; i < nbits; i++) dev_bit(b[i]);
        if (nbits == 8) begin
            dev_bit((~^b) ^ flip_par);
            dev_bit(1'b1);
        end
        dev_d = 1'b1;
        repeat (2 * HALF) @(negedge clock);
    endtask

    task automatic expect_ev(input logic e, input logic m, input logic [7:0] c);
        exp_q.push_back({e, m, c});
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [7:0] ov_codes [5];
        logic [9:0] tx_exp;
        int t;
        int inh;
        int seen;
        ov_codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
        tx_exp = 10'b1_1_11101101;

        reset  = 1'b0;
        ready  = 1'b1;
        txStrb = 1'b0;
        txData = 8'h00;
        repeat (4) @(negedge clock);
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_head", {22'b0, ext, make, code}, 32'd0);
        check("rst_pulses", {29'b0, overflow, frameErr, txAck}, 32'd0);
        check("rst_tx", {29'b0, ps2CkO, ps2DO, txBusy}, 32'd0);
        reset = 1'b1;
        repeat (10) @(negedge clock);

        // plain make code
        expect_ev(1'b0, 1'b1, 8'h1C);
        send_frame(8'h1C, 1'b0, 8);

        // extended break, then plain make of the same code
        expect_ev(1'b1, 1'b0, 8'h75);
        send_frame(8'hE0, 1'b0, 8);
        send_frame(8'hF0, 1'b0, 8);
        send_frame(8'h75, 1'b0, 8);
        expect_ev(1'b0, 1'b1, 8'h75);
        send_frame(8'h75, 1'b0, 8);
        check("fe_none", fe_cnt, 0);

        // parity error, then recovery
        send_frame(8'h1C, 1'b1, 8);
        check("fe_parity", fe_cnt, 1);
        check("parity_no_event", exp_q.size(), 0);
        expect_ev(1'b0, 1'b1, 8'h1C);
        send_frame(8'h1C, 1'b0, 8);

        // overflow: consumer stalled
        ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (i < DEPTH) expect_ev(1'b0, 1'b1, ov_codes[i]);
            send_frame(ov_codes[i], 1'b0, 8);
        end
        check("overflow_cnt", ov_cnt, 1);
        check("head_stable", {22'b0, valid, ext, make, code}, {22'b0, 1'b1, 1'b0, 1'b1, 8'h16});
        repeat (20) @(negedge clock);
        check("head_stable2", {24'b0, code}, 32'h16);
        ready = 1'b1;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clock);
            t++;
        end
        check("drain", exp_q.size(), 0);
        check("overflow_once", ov_cnt, 1);

        // watchdog: clock stops after 4 data bits
        send_frame(8'h1C, 1'b0, 4);
        repeat (2 * (2 ** TW) + 40) @(negedge clock);
        check("fe_timeout", fe_cnt, 2);
        expect_ev(1'b0, 1'b1, 8'h1C);
        send_frame(8'h1C, 1'b0, 8);
        check("after_timeout", exp_q.size(), 0);

`ifdef PS2_TX_EN
        @(negedge clock);
        txData = 8'hED;
        txStrb = 1'b1;
        repeat (2) @(negedge clock);
        txStrb = 1'b0;
        t = 0;
        while (!ps2CkO && t < 20) begin
            @(negedge clock);
            t++;
        end
        inh = 0;
        t = 0;
        while (ps2CkO && t < 4 * INH + 20) begin
            if (ce) inh++;
            @(negedge clock);
            t++;
        end
        $display("tx inhibit ce ticks=%0d", inh);
        check("tx_inhibit", inh, INH);
        check("tx_req", {29'b0, ps2CkO, ps2DO, txBusy}, 32'b011);
        for (int i = 0; i < 11; i++) begin
            repeat (HALF) @(negedge clock);
            if (i == 10) dev_d = 1'b0;
            dev_ck = 1'b0;
            repeat (HALF) @(negedge clock);
            if (i < 10) begin
                $display("tx bit %0d line=%b expected %b", i, ps2DI, tx_exp[i]);
                check("tx_bit", {31'b0, ps2DI}, {31'b0, tx_exp[i]});
            end
            dev_ck = 1'b1;
            dev_d  = 1'b1;
        end
        t = 0;
        while (txBusy && t < 100) begin
            @(negedge clock);
            t++;
        end
        check("tx_ack", ack_cnt, 1);
        check("tx_idle", {29'b0, ps2CkO, ps2DO, txBusy}, 32'd0);
        check("tx_no_err", fe_cnt, 2);
`else
        @(negedge clock);
        txData = 8'hED;
        txStrb = 1'b1;
        repeat (2) @(negedge clock);
        txStrb = 1'b0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (ps2CkO || ps2DO || txBusy || txAck) seen = 1;
        end
        $display("tx disabled build: strobe issued, activity=%0d", seen);
        check("tx_disabled", seen, 0);
`endif

        repeat (100) @(negedge clock);
        check("queue_empty", exp_q.size(), 0);
        check("fe_final", fe_cnt, 2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_host.md
# ps2_host

Parametrised PS/2 keyboard host port: glitch-filtered receiver, scan-code prefix decoder and output FIFO, with an optional host-to-device transmitter. Sits between the board PS/2 pins and the keyboard matrix/command logic. Consumers see decoded key events (code, make/break, extended) through a valid/ready FIFO rather than single-cycle strobes.

## Interface
- FILTER, 8: ce samples of stable clock line needed to accept a level change (2..16)
- FIFO_DEPTH, 4: event FIFO entries, power of two (2..16)
- TIMEOUT_W, 12: width of frame watchdog; timeout at 2^TIMEOUT_W-1 ce ticks without a falling edge mid-frame
- INHIBIT, 1000: ce ticks clock is held low before a transmit
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- ce  in  1  sample enable; all state except FIFO read side advances only when ce=1
- ps2CkI  in  1  raw PS/2 clock pin
- ps2DI  in  1  raw PS/2 data pin
- ps2CkO  out  1  1 = drive clock pin low (open-drain)
- ps2DO  out  1  1 = drive data pin low (open-drain)
- valid  out  1  FIFO head valid
- ready  in  1  consumer accepts head when valid&ready
- make  out  1  head is key press (0 = release)
- ext  out  1  head was E0-prefixed
- code  out  8  head scan code
- overflow  out  1  one-cycle pulse: event dropped, FIFO full
- frameErr  out  1  one-cycle pulse: start/parity/stop error or timeout
- txStrb  in  1  request transmit of txData (sampled on ce)
- txData  in  8  byte to send
- txBusy  out  1  transmit in progress
- txAck  out  1  one-cycle pulse: device acknowledged

## Operation
- Input sync: two flops on each pin. Clock filter: shift register of FILTER samples; all-1 sets filtered clock high, all-0 sets it low; high→low transition produces one-ce fall event.
- Receive FSM on fall events: IDLE (data=0 → DATA, else stay) → DATA (8 bits LSB first) → PARITY → STOP. Frame good iff odd parity over data+parity bit and stop=1.
- Good frame: E0 sets ext flag, F0 clears make flag (default 1); neither pushes. Any other byte pushes {ext, make, code}, then flags reset to ext=0, make=1. E1 pushes as ordinary code.
- Bad frame or timeout: return to IDLE, discard byte, reset prefix flags, pulse frameErr.
- FIFO: push when not full; full → drop, pulse overflow. Pop on valid&ready, independent of ce. Simultaneous pop and push when full: both occur.
- Transmit (PS2_TX_EN): txStrb while not busy and receive FSM in IDLE latches txData, txBusy=1. States INHIBIT (ps2CkO=1 for INHIBIT ticks) → REQ (release clock, ps2DO=1) → BITS (on each fall event present next bit: 8 data LSB first, odd parity, then release for stop) → ACK (next fall event: data low → txAck pulse, else frameErr) → IDLE, txBusy=0. txStrb while busy ignored. Receiver disabled while txBusy; frame watchdog also guards BITS/ACK (timeout → frameErr, release pins, IDLE).

## Timing
- Reset values: ps2CkO=0, ps2DO=0, valid=0, make=0, ext=0, code=0, overflow=0, frameErr=0, txBusy=0, txAck=0; filter register all 1, filtered clock 1, FSMs IDLE, FIFO empty, flags ext=0/make=1.
- Reset mid-frame or mid-transmit: pins released immediately (asynchronous), partial frame lost.
- Fall event one ce after FILTER-th zero sample; data bit sampled from synchronized data at that event.
- Push occurs on the ce following the stop-bit event; valid rises the next clock; head outputs are registered, stable while valid&!ready.
- Watchdog counts only ce ticks in non-IDLE states, cleared on each fall event.

## Configuration
- PS2_TX_EN defined: transmitter present as above.
- Undefined: ps2CkO=0, ps2DO=0, txBusy=0, txAck=0 constant; txStrb/txData ignored; ports remain.

## Structure
- Package ps2_pkg: receive and transmit state enums, event typedef {ext, make, code[7:0]}, constants PS2_EXT=8'hE0, PS2_BRK=8'hF0.
- Sub-module ps2_fifo: parametrised synchronous FIFO (push/pop/full/empty), event width from package.

## Test plan
- Frame 0x1C, odd parity good, ready=1 → one event make=1 ext=0 code=1C; no frameErr.
- Sequence E0,F0,75 → single event make=0 ext=1 code=75; next 75 → make=1 ext=0.
- 0x1C with parity bit inverted → frameErr pulse, no event; following good 0x1C accepted normally.
- ready=0, send FIFO_DEPTH+1 codes → first FIFO_DEPTH held in order, overflow pulses once; draining yields original codes.
- Clock stops after 4 data bits for 2^TIMEOUT_W ticks → frameErr, FSM IDLE, next frame decodes correctly.
- PS2_TX_EN, txStrb with 0xED → clock held low INHIBIT ticks, bits 1,0,1,1,0,1,1,1 then parity 1 on device clock; device ACK → txAck pulse, txBusy falls.
